pwm_generator_bank: RTL and testbench
=====================================

PWM_GENERATOR_BANK -- requirements
Module: pwm_generator_bank

Interface
REQ-001 Parameter: PERIOD_TOP, default 8'd254, terminal value of the shared period counter.
REQ-002 clk  input  1  system clock; all logic SHALL be clocked on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 en_out  input  8  per-output enable; bit i gates pwm_out[i].
REQ-005 en_pwm_out  input  8  per-output mode; 1 = PWM, 0 = static high when enabled.
REQ-006 chan_sel_lo  input  8  generator select for outputs 3..0; bits [2i+1:2i] serve output i.
REQ-007 chan_sel_hi  input  8  generator select for outputs 7..4; bits [2(i-4)+1:2(i-4)] serve output i.
REQ-008 duty_1 .. duty_4  input  8 each  duty cycles of generators 1..4.
REQ-009 freq_div  input  4  prescaler exponent; tick period = 2^freq_div clk cycles.
REQ-010 pwm_out  output  8  registered output pins.
REQ-011 period_start  output  1  one-clk pulse marking the start of each PWM period.

Function
REQ-012 The block SHALL hold a 15-bit prescaler counter that emits tick when it equals 2^div_sh - 1, then returns to 0; div_sh = 0 SHALL give a tick every clk.
REQ-013 The block SHALL hold an 8-bit period counter that increments on tick and wraps from PERIOD_TOP to 0 (wrap event); the period SHALL be (PERIOD_TOP+1) * 2^div_sh clk cycles.
REQ-014 Shadow registers duty_sh[1..4] and div_sh SHALL load from duty_1..4 and freq_div on the wrap event and on the first clk after reset release; at no other time.
REQ-015 On a wrap event the prescaler SHALL also restart at 0, so a new div_sh applies from the first tick of the new period.
REQ-016 Generator g raw level SHALL be 1 when period counter < duty_sh[g], else 0; duty 0 = always low, duty 255 = always high (counter never exceeds 254).
REQ-017 Selection code 0,1,2,3 SHALL route generator 1,2,3,4 respectively.
REQ-018 pwm_out[i] next value SHALL be: en_out[i]=0 -> 0; en_out[i]=1 and en_pwm_out[i]=0 -> 1; else raw level of the selected generator.
REQ-019 en_out, en_pwm_out and chan_sel_* SHALL NOT be shadowed; a change SHALL appear on pwm_out one clk later.
REQ-020 pwm_out SHALL lag the period counter by exactly one clk.
REQ-021 period_start SHALL be high for exactly one clk, aligned to the first clk in which pwm_out reflects counter value 0 of a new period, including the first period after reset.
REQ-022 Changes to duty/freq_div mid-period SHALL NOT alter the current period; only the value present on the wrap edge SHALL be captured.
REQ-023 Simultaneous wrap and input change SHALL capture the input value sampled on that edge.

Reset
REQ-024 While rst_n=0: prescaler, period counter, all shadows, pwm_out and period_start SHALL be 0, asynchronously.
REQ-025 After release the counter SHALL start at 0, shadows SHALL load on the first clk, and period_start SHALL pulse at the start of that first period.
REQ-026 Reset asserted mid-period SHALL abort the period with no glitch beyond forcing outputs to 0.

Verification
REQ-027 freq_div=0, duty_1=128, en_out=0x01, en_pwm_out=0x01, chan_sel_lo=0 -> pwm_out[0] high 128 clks, low 127 clks, period_start every 255 clks.
REQ-028 duty_2=0 and duty_3=255, outputs 1/2 selecting gen 2/3 -> pwm_out[1] constant 0, pwm_out[2] constant 1 across 3 periods.
REQ-029 en_out=0xFF, en_pwm_out=0x00 -> pwm_out=0xFF one clk later; en_out=0x00 -> pwm_out=0x00 one clk later.
REQ-030 duty_1 changed 64 -> 192 at count 100 -> current period 64 high clks, next period 192, change aligned to period_start.
REQ-031 freq_div=3, duty_4=10, output 7 selects gen 4 -> period 2040 clks, high 80 clks; freq_div changed mid-period takes effect only at next period.
REQ-032 rst_n pulsed low at count 150 -> pwm_out=0 immediately; after release period_start pulses and counting restarts from 0 with current duty.

Source files
------------

// File: rtl/pwm_generator_bank_if.sv
// Control and pin bundle for pwm_generator_bank: enables, routing, duty/prescaler settings and outputs.
interface pwm_generator_bank_if;
  logic [7:0] en_out;
  logic [7:0] en_pwm_out;
  logic [7:0] chan_sel_lo;
  logic [7:0] chan_sel_hi;
  logic [7:0] duty_1;
  logic [7:0] duty_2;
  logic [7:0] duty_3;
  logic [7:0] duty_4;
  logic [3:0] freq_div;
  logic [7:0] pwm_out;
  logic       period_start;

  modport master (
    output en_out, en_pwm_out, chan_sel_lo, chan_sel_hi,
    output duty_1, duty_2, duty_3, duty_4, freq_div,
    input  pwm_out, period_start
  );

  modport slave (
    input  en_out, en_pwm_out, chan_sel_lo, chan_sel_hi,
    input  duty_1, duty_2, duty_3, duty_4, freq_div,
    output pwm_out, period_start
  );
endinterface

// File: rtl/pwm_generator_bank.sv
// Four PWM generators sharing one prescaled period counter, routed to eight gated output pins.
// Duty and prescaler settings are shadowed and only change at period boundaries.
module pwm_generator_bank #(
  parameter logic [7:0] PERIOD_TOP = 8'd254
) (
  input logic                clk,
  input logic                rst_n,
  pwm_generator_bank_if.slave bus
);

  localparam int unsigned PRE_W  = 15;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned DUTY_W = 8;
  localparam int unsigned DIV_W  = 4;
  localparam int unsigned N_GEN  = 4;
  localparam int unsigned N_OUT  = 8;
  localparam int unsigned SEL_W  = 2;

  logic [PRE_W-1:0]              pre_q;
  logic [CNT_W-1:0]              cnt_q;
  logic [N_GEN-1:0][DUTY_W-1:0]  duty_sh;
  logic [DIV_W-1:0]              div_sh;
  logic                          started_q;
  logic                          load_q;

  logic [PRE_W-1:0]              pre_top_c;
  logic                          tick_c;
  logic                          wrap_c;
  logic                          load_c;
  logic [N_GEN-1:0]              raw_c;
  logic [SEL_W*N_OUT-1:0]        sel_c;
  logic [N_OUT-1:0]              pwm_next_c;

  // The first clock after reset behaves like a wrap: counters stay at 0 and shadows load.
  always_comb begin
    pre_top_c = PRE_W'((32'd1 << div_sh) - 32'd1);
    tick_c    = (pre_q == pre_top_c);
    wrap_c    = started_q & tick_c & (cnt_q == PERIOD_TOP);
    load_c    = ~started_q | wrap_c;
  end

  // Generator levels and per-pin routing; enables and selects act unshadowed.
  always_comb begin
    raw_c      = '0;
    pwm_next_c = '0;
    sel_c      = {bus.chan_sel_hi, bus.chan_sel_lo};
    for (int unsigned g = 0; g < N_GEN; g++) begin
      raw_c[g] = (cnt_q < duty_sh[g]);
    end
    for (int unsigned i = 0; i < N_OUT; i++) begin
      pwm_next_c[i] = bus.en_out[i] & (~bus.en_pwm_out[i] | raw_c[sel_c[SEL_W*i +: SEL_W]]);
    end
  end

  // period_start trails the load by two clocks so it lines up with pwm_out showing count 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q            <= '0;
      cnt_q            <= '0;
      duty_sh          <= '0;
      div_sh           <= '0;
      started_q        <= 1'b0;
      load_q           <= 1'b0;
      bus.period_start <= 1'b0;
      bus.pwm_out      <= '0;
    end else begin
      started_q        <= 1'b1;
      load_q           <= load_c;
      bus.period_start <= load_q;
      bus.pwm_out      <= pwm_next_c;
      if (load_c) begin
        pre_q      <= '0;
        cnt_q      <= '0;
        duty_sh[0] <= bus.duty_1;
        duty_sh[1] <= bus.duty_2;
        duty_sh[2] <= bus.duty_3;
        duty_sh[3] <= bus.duty_4;
        div_sh     <= bus.freq_div;
      end else if (tick_c) begin
        pre_q <= '0;
        cnt_q <= cnt_q + CNT_W'(1);
      end else begin
        pre_q <= pre_q + PRE_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pwm_generator_bank.sv
// Randomized and directed bench for pwm_generator_bank against a time-in-period reference model.
module tb_pwm_generator_bank;

  localparam int TOP = 254;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pwm_generator_bank_if bus();

  pwm_generator_bank #(.PERIOD_TOP(8'd254)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference: clocks elapsed in the current period plus the settings captured for it.
  bit m_started;
  int m_t;
  int m_duty [4];
  int m_div;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, wanted %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic void m_reset();
    m_started = 1'b0;
    m_t       = 0;
    m_div     = 0;
    for (int k = 0; k < 4; k++) m_duty[k] = 0;
  endfunction

  function automatic void m_load();
    m_duty[0] = int'(bus.duty_1);
    m_duty[1] = int'(bus.duty_2);
    m_duty[2] = int'(bus.duty_3);
    m_duty[3] = int'(bus.duty_4);
    m_div     = int'(bus.freq_div);
  endfunction

  function automatic logic [7:0] m_pwm();
    logic [7:0]  r;
    logic [15:0] s;
    int          cnt;
    int          g;
    r   = '0;
    s   = {bus.chan_sel_hi, bus.chan_sel_lo};
    cnt = m_t / (1 << m_div);
    for (int i = 0; i < 8; i++) begin
      g = int'(s[2*i +: 2]);
      if (!bus.en_out[i])          r[i] = 1'b0;
      else if (!bus.en_pwm_out[i]) r[i] = 1'b1;
      else                         r[i] = (cnt < m_duty[g]);
    end
    return r;
  endfunction

  // One clock: predict from pre-edge state, advance the model, then compare after the edge.
  task automatic step();
    logic [7:0] e_pwm;
    logic       e_ps;
    @(posedge clk);
    if (!rst_n) begin
      m_reset();
      e_pwm = '0;
      e_ps  = 1'b0;
    end else begin
      e_pwm = m_pwm();
      e_ps  = m_started && (m_t == 0);
      if (!m_started) begin
        m_load();
        m_t       = 0;
        m_started = 1'b1;
      end else if (m_t == (TOP + 1) * (1 << m_div) - 1) begin
        m_load();
        m_t = 0;
      end else begin
        m_t++;
      end
    end
    #1;
    chk("pwm_out", 32'(bus.pwm_out), 32'(e_pwm));
    chk("period_start", 32'(bus.period_start), 32'(e_ps));
  endtask

  task automatic wait_ps(input int budget);
    bit got;
    got = 1'b0;
    for (int k = 0; k < budget && !got; k++) begin
      step();
      got = bus.period_start;
    end
    chk("ps_timeout", 32'(got), 32'd1);
  endtask

  // Starting on a period_start cycle, measure one period of pin b; optionally change settings at offset chg_at.
  task automatic measure(input int b, input int chg_at, input int chg_duty, input int chg_div,
                         output int len, output int hi);
    bit done;
    done = 1'b0;
    len  = 0;
    hi   = 0;
    for (int k = 0; k < 5000 && !done; k++) begin
      hi += int'(bus.pwm_out[b]);
      len++;
      if (k == chg_at) begin
        if (chg_duty >= 0) bus.duty_1   = 8'(chg_duty);
        if (chg_div >= 0)  bus.freq_div = 4'(chg_div);
      end
      step();
      done = bus.period_start;
    end
    chk("measure_timeout", 32'(done), 32'd1);
  endtask

  initial begin
    int len;
    int hi;
    int ones1;
    int ones2;

    m_reset();
    bus.en_out      = 8'h01;
    bus.en_pwm_out  = 8'h01;
    bus.chan_sel_lo = 8'h00;
    bus.chan_sel_hi = 8'h00;
    bus.duty_1      = 8'd128;
    bus.duty_2      = 8'($urandom);
    bus.duty_3      = 8'($urandom);
    bus.duty_4      = 8'($urandom);
    bus.freq_div    = 4'd0;

    #2;
    chk("reset_pwm", 32'(bus.pwm_out), 32'd0);
    chk("reset_ps", 32'(bus.period_start), 32'd0);
    repeat (3) step();
    rst_n = 1'b1;

    // 128 high / 127 low at divider 0, starting with the first period after reset.
    wait_ps(3);
    for (int p = 0; p < 3; p++) begin
      measure(0, -1, -1, -1, len, hi);
      chk("p27_len", 32'(len), 32'd255);
      chk("p27_hi", 32'(hi), 32'd128);
    end

    // Duty 0 and 255 extremes on pins 1 and 2.
    bus.duty_2      = 8'd0;
    bus.duty_3      = 8'd255;
    bus.en_out      = 8'h07;
    bus.en_pwm_out  = 8'h07;
    bus.chan_sel_lo = 8'h24;
    wait_ps(600);
    wait_ps(600);
    ones1 = 0;
    ones2 = 0;
    for (int k = 0; k < 3 * 255; k++) begin
      ones1 += int'(bus.pwm_out[1]);
      ones2 += int'(bus.pwm_out[2]);
      step();
    end
    chk("duty0_ones", 32'(ones1), 32'd0);
    chk("duty255_ones", 32'(ones2), 32'd765);

    // Static-high and disable both land one clock later.
    bus.en_out     = 8'hFF;
    bus.en_pwm_out = 8'h00;
    step();
    chk("static_high", 32'(bus.pwm_out), 32'hFF);
    bus.en_out = 8'h00;
    step();
    chk("all_off", 32'(bus.pwm_out), 32'h00);

    // Mid-period duty change only takes effect at the next period.
    bus.en_out      = 8'h01;
    bus.en_pwm_out  = 8'h01;
    bus.chan_sel_lo = 8'h00;
    bus.duty_1      = 8'd64;
    wait_ps(600);
    wait_ps(600);
    measure(0, 100, 192, -1, len, hi);
    chk("p30_cur_hi", 32'(hi), 32'd64);
    chk("p30_cur_len", 32'(len), 32'd255);
    measure(0, -1, -1, -1, len, hi);
    chk("p30_next_hi", 32'(hi), 32'd192);

    // Divider 3 on gen 4 via pin 7, then a mid-period divider change.
    bus.en_out      = 8'h80;
    bus.en_pwm_out  = 8'h80;
    bus.chan_sel_hi = 8'hC0;
    bus.duty_4      = 8'd10;
    bus.freq_div    = 4'd3;
    wait_ps(600);
    wait_ps(3000);
    measure(7, 1000, -1, 1, len, hi);
    chk("p31_len", 32'(len), 32'd2040);
    chk("p31_hi", 32'(hi), 32'd80);
    measure(7, -1, -1, -1, len, hi);
    chk("p31_next_len", 32'(len), 32'd510);
    chk("p31_next_hi", 32'(hi), 32'd20);

    // Random settings at small dividers, checked every clock against the model.
    for (int k = 0; k < 6000; k++) begin
      if ($urandom_range(0, 7) == 0) begin
        bus.en_out      = 8'($urandom);
        bus.en_pwm_out  = 8'($urandom);
        bus.chan_sel_lo = 8'($urandom);
        bus.chan_sel_hi = 8'($urandom);
      end
      if ($urandom_range(0, 63) == 0) begin
        bus.duty_1   = ($urandom_range(0, 3) == 0) ? 8'd0   : 8'($urandom);
        bus.duty_2   = ($urandom_range(0, 3) == 0) ? 8'd255 : 8'($urandom);
        bus.duty_3   = 8'($urandom);
        bus.duty_4   = 8'($urandom);
        bus.freq_div = 4'($urandom_range(0, 2));
      end
      step();
    end

    // Reset mid-period forces outputs low at once and restarts cleanly.
    bus.en_out      = 8'h01;
    bus.en_pwm_out  = 8'h01;
    bus.chan_sel_lo = 8'h00;
    bus.duty_1      = 8'd100;
    bus.freq_div    = 4'd0;
    wait_ps(3000);
    wait_ps(3000);
    repeat (150) step();
    rst_n = 1'b0;
    m_reset();
    #1;
    chk("p32_rst_pwm", 32'(bus.pwm_out), 32'd0);
    chk("p32_rst_ps", 32'(bus.period_start), 32'd0);
    repeat (3) step();
    rst_n = 1'b1;
    wait_ps(3);
    measure(0, -1, -1, -1, len, hi);
    chk("p32_len", 32'(len), 32'd255);
    chk("p32_hi", 32'(hi), 32'd100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
